// File: rtl/load_stage_if.sv
// load_stage_if: word-stream input and block output bundle of the SHAKE absorb stage
interface load_stage_if #(
    parameter int W    = 64,
    parameter int RATE = 1344
);
    logic [W-1:0]    data_in;
    logic            valid_i;
    logic            ready_o;
    logic            last_i;
    logic [3:0]      last_len_i;
    logic [1:0]      operation_mode_in;
    logic [RATE-1:0] block_o;
    logic            block_valid_o;
    logic            block_ready_i;
    logic            block_last_o;
    logic [1:0]      operation_mode_o;
    modport master (
        output data_in, valid_i, last_i, last_len_i, operation_mode_in, block_ready_i,
        input  ready_o, block_o, block_valid_o, block_last_o, operation_mode_o
    );
    modport slave (
        input  data_in, valid_i, last_i, last_len_i, operation_mode_in, block_ready_i,
        output ready_o, block_o, block_valid_o, block_last_o, operation_mode_o
    );
endinterface

// File: rtl/load_stage.sv
// load_stage: packs message words into rate-wide blocks; SHAKE padding when LOAD_STAGE_PAD_EN is defined
module load_stage #(
    parameter int W    = 64,
    parameter int RATE = 1344
) (
    input logic         clk,
    input logic         rst,
    load_stage_if.slave bus
);
    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;
    localparam int AW = $clog2(RATE);

`ifdef LOAD_STAGE_PAD_EN
    typedef enum logic [1:0] {FILL, FULL, PADBLK} state_t;
`else
    typedef enum logic [1:0] {FILL, FULL} state_t;
`endif

    state_t          state_q;
    logic [4:0]      idx_q;
    logic [RATE-1:0] blk_q, blk_d;
    logic            ready_q, valid_q, last_q, start_q;
    logic [1:0]      mode_q, mode_cur;
    logic [4:0]      depth;
    logic            acc, done;

    // The first word of a message uses the incoming mode before it is latched
    assign mode_cur = start_q ? bus.operation_mode_in : mode_q;
    assign depth    = mode_cur == SHAKE256_MODE_VEC ? 5'd17 : 5'd21;
    assign acc      = bus.valid_i && bus.ready_o;
    assign done     = bus.last_i || idx_q == depth - 5'd1;

    assign bus.ready_o          = ready_q && rst;
    assign bus.block_o          = blk_q;
    assign bus.block_valid_o    = valid_q;
    assign bus.block_last_o     = last_q;
    assign bus.operation_mode_o = mode_q;

`ifdef LOAD_STAGE_PAD_EN
    localparam int BPW = W / 8;
    logic [3:0]      len;
    logic            full_tail, pend_q;
    logic [W-1:0]    word_pad;
    logic [RATE-1:0] pad_blk;
    logic [4:0]      depth_q;

    assign len       = bus.last_len_i > 4'(BPW) ? 4'(BPW) : bus.last_len_i;
    assign full_tail = len == 4'(BPW) && idx_q == depth - 5'd1;
    assign depth_q   = mode_q == SHAKE256_MODE_VEC ? 5'd17 : 5'd21;

    // Keep the valid bytes of the final word and place the 0x1F domain byte right after them
    always_comb begin
        word_pad = '0;
        for (int b = 0; b < BPW; b++)
            word_pad[8*b +: 8] = len > 4'(b) ? bus.data_in[8*b +: 8] : (len == 4'(b) ? 8'h1F : 8'h00);
    end

    // Merge the accepted word; a final word also spills 0x1F into the next word and sets the closing 0x80
    always_comb begin
        blk_d = blk_q;
        blk_d[AW'(W*idx_q) +: W] = bus.last_i ? word_pad : bus.data_in;
        if (bus.last_i && len == 4'(BPW) && idx_q != depth - 5'd1)
            blk_d[AW'(W*(idx_q + 5'd1)) +: 8] = 8'h1F;
        if (bus.last_i && !full_tail)
            blk_d[AW'(W*depth) - AW'(8) +: 8] = blk_d[AW'(W*depth) - AW'(8) +: 8] | 8'h80;
    end

    // Block made of padding only, used when the message exactly filled the previous block
    always_comb begin
        pad_blk = '0;
        pad_blk[7:0] = 8'h1F;
        pad_blk[AW'(W*depth_q) - AW'(8) +: 8] = 8'h80;
    end
`else
    logic unused_len;
    assign unused_len = ^bus.last_len_i;

    // Source supplies pre-padded words; just drop each one into its slot
    always_comb begin
        blk_d = blk_q;
        blk_d[AW'(W*idx_q) +: W] = bus.data_in;
    end
`endif

    // Fill / hold / pad-block sequencing with registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            blk_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            start_q <= 1'b1;
            mode_q  <= '0;
`ifdef LOAD_STAGE_PAD_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: if (acc) begin
                    blk_q <= blk_d;
                    if (start_q) begin
                        mode_q  <= bus.operation_mode_in;
                        start_q <= 1'b0;
                    end
                    if (done) begin
                        state_q <= FULL;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
`ifdef LOAD_STAGE_PAD_EN
                        last_q  <= bus.last_i && !full_tail;
                        pend_q  <= bus.last_i && full_tail;
`else
                        last_q  <= bus.last_i;
`endif
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                FULL: if (bus.block_ready_i) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    start_q <= last_q;
`ifdef LOAD_STAGE_PAD_EN
                    if (pend_q) begin
                        state_q <= PADBLK;
                        pend_q  <= 1'b0;
                    end else
`endif
                    begin
                        state_q <= FILL;
                        ready_q <= 1'b1;
                        blk_q   <= '0;
                        idx_q   <= '0;
                    end
                end
`ifdef LOAD_STAGE_PAD_EN
                PADBLK: begin
                    blk_q   <= pad_blk;
                    last_q  <= 1'b1;
                    valid_q <= 1'b1;
                    state_q <= FULL;
                end
`endif
                default: state_q <= FILL;
            endcase
        end
    end
endmodule

// File: doc/load_stage.md
# load_stage

Input (absorb-side) stage of the SHAKE core. Accepts the message as a stream of `w`-bit words over a valid/ready handshake, packs them into a rate-wide block, applies SHAKE padding, and hands complete blocks to the permutation stage. It is the mirror of the output dump stage, which does the reverse: rate-wide block in, words out. Supports SHAKE128 (21-word rate) and SHAKE256 (17-word rate), selected per message.

## Interface
Parameters:
- `W`, default `w` (from `keccak_pkg`, 64): data word width in bits.
- `RATE`, default `RATE_SHAKE128` (1344): block register width in bits.

Ports:
- `clk`  input  1  clock; all logic rising-edge.
- `rst`  input  1  reset; synchronous, active-low (asserted when 0).
- `data_in`  input  W  message word; byte k at bits [8k+7:8k].
- `valid_i`  input  1  `data_in`, `last_i` and `last_len_i` are valid.
- `ready_o`  output  1  stage accepts a word this cycle.
- `last_i`  input  1  current word is the final word of the message.
- `last_len_i`  input  4  valid bytes in the final word, 0..8; ignored unless `last_i`.
- `operation_mode_in`  input  2  `SHAKE128_MODE_VEC` / `SHAKE256_MODE_VEC`; sampled on the first word of a message.
- `block_o`  output  RATE  absorbed block; word i at bits [W*i +: W].
- `block_valid_o`  output  1  `block_o` holds a complete block.
- `block_ready_i`  input  1  next stage takes the block.
- `block_last_o`  output  1  `block_o` is the final (padded) block of the message.
- `operation_mode_o`  output  2  mode latched for the current message.

## Operation
- Depth D = 21 for SHAKE128, 17 for SHAKE256; any other mode code is treated as SHAKE128. Block bits at or above D*W are always 0.
- Word transfer: `valid_i && ready_o`. Block transfer: `block_valid_o && block_ready_i`.
- A 5-bit word counter `idx` runs from 0 to D-1. Each accepted word is written to word `idx`.
- The flag `msg_start` is set at reset and after each last block is transferred. The first word accepted while it is set latches `operation_mode_in` and clears the flag.
- FSM states:
  - FILL: `ready_o`=1.
    - Non-last word with `idx`=D-1 → FULL, `block_last_o`=0.
    - Last word → apply padding → FULL, or → FULL_PREPAD (see below).
  - FULL: `ready_o`=0, `block_valid_o`=1. On transfer:
    - If a pad block is pending → PADBLK.
    - Otherwise → FILL; the buffer is cleared and `idx`=0.
  - PADBLK: the buffer is loaded with a pure pad block (byte 0 = 0x1F, byte 8D-1 = 0x80, rest 0), `block_last_o`=1 → FULL. This takes one cycle.
- Padding for a last word at index k with length L:
  - Bytes at or above L in word k are masked to 0.
  - If L<8: byte L of word k = 0x1F.
  - If L=8 and k<D-1: byte 0 of word k+1 = 0x1F.
  - All later words are 0.
  - Byte 8D-1 is ORed with 0x80. If 0x1F and 0x80 land on the same byte, the result is 0x9F.
  - Case L=8 and k=D-1: the block goes out with `block_last_o`=0 and a pad block is pending (state FULL_PREPAD is FULL with the pending flag set).
- `last_len_i` greater than 8 is treated as 8.
- An empty message is a single last word with `last_len_i`=0.

## Timing
- Reset values: `ready_o`=0 while `rst`=0 and 1 on the first cycle after release. `block_valid_o`=0, `block_last_o`=0, `block_o`=0, `operation_mode_o`=0, `idx`=0, state FILL.
- `block_valid_o` rises on the cycle after the word that completes the block (1-cycle latency).
- `block_o`, `block_last_o` and `operation_mode_o` are stable while `block_valid_o`=1 and not transferred.
- After a block transfer, `ready_o`=1 on the next cycle. Exception: the pending pad path adds one PADBLK cycle before the second block is valid.
- There is no overlap between filling and holding. Throughput is D words per D+1 cycles when the consumer is always ready.
- Reset asserted mid-block discards all partial data and any pending pad.
- `valid_i` while `ready_o`=0 is ignored; the source must hold its word.

## Configuration
- `LOAD_STAGE_PAD_EN` defined: padding logic as described above.
- Not defined:
  - No padding; `last_len_i` is ignored and the PADBLK state does not exist.
  - The source supplies pre-padded data, and `last_i` only sets `block_last_o` on the block it completes.
  - `last_i` on a word with `idx`<D-1 still emits the block, with the remaining words 0.

## Test plan
- SHAKE128, empty message (one word, `last_i`=1, `last_len_i`=0) → one block: byte 0 = 0x1F, byte 167 = 0x80, `block_last_o`=1.
- SHAKE256, 3 words, last with L=3 → word 2 = data[23:0] | 0x1F<<24, byte 135 = 0x80, bits at or above 1088 are 0; `block_valid_o` high 1 cycle after the 3rd word.
- SHAKE256, 17 full words, `last_i` on the 17th with L=8 → block 1 with `block_last_o`=0, then after PADBLK a block of 0x1F…0x80 with `block_last_o`=1.
- SHAKE128, 21 words, last L=7 → byte 167 = 0x9F.
- `block_ready_i` held 0 for 10 cycles → `ready_o`=0 and `block_o` unchanged throughout; `operation_mode_in` toggled mid-message → `operation_mode_o` unchanged.
- `rst`=0 after 5 words, then release → `idx`=0, `block_valid_o`=0; a fresh 1-word message yields a correct single block.
